// File: rtl/debounce_multi.sv
// N-channel switch debouncer: per-channel synchroniser, shared tick
// prescaler, stable-tick FSM, registered level plus rise/fall strobes.
module debounce_multi #(
  parameter int CH           = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = $clog2(STABLE_TICKS + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(STABLE_TICKS - 1);

  // State bit 1 doubles as the debounced level.
  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] W1 = 2'b01;
  localparam logic [1:0] S1 = 2'b10;
  localparam logic [1:0] W0 = 2'b11;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  assign cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;

  // Tick is aligned with the cycle in which cnt reads its last value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == CNT_MAX);
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [1:0]             st;
    logic [1:0]             st_nxt;
    logic [TW-1:0]          tcnt;
    logic [TW-1:0]          tcnt_nxt;
    logic                   r_nxt;
    logic                   f_nxt;
    logic                   db_q;
    logic                   rise_q;
    logic                   fall_q;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
      st_nxt   = st;
      tcnt_nxt = tcnt;
      r_nxt    = 1'b0;
      f_nxt    = 1'b0;
      case (st)
        S0: begin
          if (s) begin
            st_nxt   = W1;
            tcnt_nxt = '0;
          end
        end
        W1: begin
          if (!s) begin
            st_nxt = S0;
          end else if (tick) begin
            tcnt_nxt = tcnt + 1'b1;
            if (tcnt == T_LAST) begin
              st_nxt = S1;
              r_nxt  = 1'b1;
            end
          end
        end
        S1: begin
          if (!s) begin
            st_nxt   = W0;
            tcnt_nxt = '0;
          end
        end
        W0: begin
          if (s) begin
            st_nxt = S1;
          end else if (tick) begin
            tcnt_nxt = tcnt + 1'b1;
            if (tcnt == T_LAST) begin
              st_nxt = S0;
              f_nxt  = 1'b1;
            end
          end
        end
        default: begin
          st_nxt   = S0;
          tcnt_nxt = '0;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q <= '0;
        st     <= S0;
        tcnt   <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw[i]};
        st     <= st_nxt;
        tcnt   <= tcnt_nxt;
        db_q   <= st_nxt[1];
        rise_q <= r_nxt;
        fall_q <= f_nxt;
      end
    end

    assign db[i]   = db_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Randomised self-checking bench for debounce_multi against a
// cycle-level behavioural model of the debounce rules.
module tb_debounce_multi;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] db;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          tick;

  int errors = 0;
  int checks = 0;

  debounce_multi #(
    .CH(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sw(sw),
    .db(db), .rise(rise), .fall(fall), .tick(tick)
  );

  always #5 clk = ~clk;

  // Model: a channel flips once its synchronised input has differed
  // from db for ST ticks (the tick of the first differing cycle ignored).
  logic [CH-1:0] hist [SS];
  logic [CH-1:0] db_m, rise_m, fall_m, diff_m;
  logic          tick_m;
  int            n_m [CH];
  int            m;

  always @(posedge clk or negedge reset_n) begin : model
    logic [CH-1:0] s;
    if (!reset_n) begin
      m = 0;
      for (int k = 0; k < SS; k++) hist[k] = '0;
      db_m = '0; rise_m = '0; fall_m = '0; diff_m = '0;
      tick_m = 1'b0;
      for (int i = 0; i < CH; i++) n_m[i] = 0;
    end else begin
      s = hist[SS-1];
      for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw;
      rise_m = '0;
      fall_m = '0;
      for (int i = 0; i < CH; i++) begin
        if (s[i] == db_m[i]) begin
          diff_m[i] = 1'b0;
        end else if (!diff_m[i]) begin
          diff_m[i] = 1'b1;
          n_m[i] = 0;
        end else if (tick_m) begin
          n_m[i]++;
          if (n_m[i] == ST) begin
            db_m[i] = s[i];
            diff_m[i] = 1'b0;
            if (s[i]) rise_m[i] = 1'b1;
            else fall_m[i] = 1'b1;
          end
        end
      end
      m++;
      tick_m = (m % TD == TD - 1);
    end
  end

  task automatic apply_reset(input logic [CH-1:0] v);
    @(negedge clk);
    reset_n = 1'b0;
    sw = v;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    int first;
    int rcnt;
    logic [CH-1:0] fany;
    @(negedge clk);
    reset_n = 1'b0;
    sw = 4'hF;
    #1;
    if ({db, rise, fall, tick} !== 13'd0) begin
      errors++;
      $display("FAIL reset_now got db=%h r=%h f=%h t=%b exp 0",
               db, rise, fall, tick);
    end
    checks++;
    repeat (3) @(negedge clk);
    if ({db, rise, fall, tick} !== 13'd0) begin
      errors++;
      $display("FAIL reset_held got db=%h r=%h f=%h t=%b exp 0",
               db, rise, fall, tick);
    end
    checks++;
    reset_n = 1'b1;
    first = -1;
    rcnt = 0;
    fany = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_reset off=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
      if (db == 4'hF && first < 0) first = i;
      if (rise == 4'hF) rcnt++;
      fany |= fall;
    end
    if (first < 11 || first > 14) begin
      errors++;
      $display("FAIL reset_latency got %0d exp 11..14", first);
    end
    checks++;
    if (rcnt != 1 || fany != '0) begin
      errors++;
      $display("FAIL reset_strobes got rise_cnt=%0d fall=%h exp 1/0",
               rcnt, fany);
    end
    checks++;
  endtask

  task automatic test_short_pulse();
    apply_reset('0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_short c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
      if (db[0] !== 1'b0 || rise[0] !== 1'b0) begin
        errors++;
        $display("FAIL short_pulse c=%0d got db0=%b r0=%b exp 0/0",
                 i, db[0], rise[0]);
      end
      checks++;
      sw[0] = (i < 6);
    end
  endtask

  task automatic test_bounce();
    logic v;
    int rcnt;
    int first;
    apply_reset('0);
    v = 1'b0;
    rcnt = 0;
    first = -1;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      v = ~v;
      sw[1] = v;
      for (int j = 0; j < 3; j++) begin
        @(negedge clk);
        if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
          errors++;
          $display("FAIL model_bounce t=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                   t, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
        end
        checks++;
        if (rise[1]) rcnt++;
      end
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_hold i=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
      if (rise[1]) rcnt++;
      if (db[1] && first < 0) first = i + 3;
    end
    if (rcnt != 1) begin
      errors++;
      $display("FAIL bounce_rise got %0d exp 1", rcnt);
    end
    checks++;
    if (first < 11 || first > 14) begin
      errors++;
      $display("FAIL bounce_latency got %0d exp 11..14", first);
    end
    checks++;
  endtask

  task automatic test_fall();
    int first;
    int fcnt;
    apply_reset(4'hF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_prefall c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
    end
    sw[2] = 1'b0;
    first = -1;
    fcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_fall off=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
      if ({db[3], db[1:0]} !== 3'b111 || rise !== '0) begin
        errors++;
        $display("FAIL fall_others off=%0d got db=%h r=%h exp db=1x11 r=0",
                 i, db, rise);
      end
      checks++;
      if (fall[2]) fcnt++;
      if (!db[2] && first < 0) first = i;
    end
    if (fcnt != 1 || first < 11 || first > 14) begin
      errors++;
      $display("FAIL fall_pulse got cnt=%0d off=%0d exp 1 at 11..14",
               fcnt, first);
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    int first;
    apply_reset('0);
    sw[3] = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_mid c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
    end
    reset_n = 1'b0;
    #1;
    if ({db, rise, fall, tick} !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset got db=%h r=%h f=%h t=%b exp 0",
               db, rise, fall, tick);
    end
    checks++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    first = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_rel off=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
      if (db[3] && first < 0) first = i;
    end
    if (first < 11 || first > 14) begin
      errors++;
      $display("FAIL mid_latency got %0d exp 11..14", first);
    end
    checks++;
  endtask

  task automatic test_tick();
    int last;
    int nt;
    last = -1;
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tick !== tick_m || (rise & fall) !== '0) begin
        errors++;
        $display("FAIL tick_free c=%0d got t=%b rf=%h exp t=%b rf=0",
                 i, tick, rise & fall, tick_m);
      end
      checks++;
      if (tick) begin
        if (last >= 0 && i - last != TD) begin
          errors++;
          $display("FAIL tick_gap c=%0d got %0d exp %0d", i, i - last, TD);
        end
        checks++;
        last = i;
        nt++;
      end
      sw = CH'($urandom);
    end
    if (nt != 100 / TD) begin
      errors++;
      $display("FAIL tick_count got %0d exp %0d", nt, 100 / TD);
    end
    checks++;
  endtask

  task automatic test_random();
    apply_reset('0);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ({db, rise, fall, tick} !== {db_m, rise_m, fall_m, tick_m}) begin
        errors++;
        $display("FAIL model_rand c=%0d got %h/%h/%h/%b exp %h/%h/%h/%b",
                 i, db, rise, fall, tick, db_m, rise_m, fall_m, tick_m);
      end
      checks++;
      if ($urandom_range(0, 5) == 0) begin
        sw[$urandom_range(0, CH - 1)] ^= 1'b1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_pulse();
    test_bounce();
    test_fall();
    test_reset_mid();
    test_tick();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
